// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-add cell, registered carry,
// start/done handshake, one operation in flight.
module serial_add_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             v_q, v_d;

  logic sum;
  logic cout;
  logic last;

  assign sum  = opa_q[0] ^ opb_q[0] ^ cy_q;
  assign cout = (opa_q[0] & opb_q[0])
              | (opa_q[0] & cy_q)
              | (opb_q[0] & cy_q);
  assign last = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    s_d     = s_q;
    c_d     = c_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = A;
          opb_d   = mode ? ~B : B;
          cy_d    = mode;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d = {1'b0, opa_q[WIDTH-1:1]};
        opb_d = {1'b0, opb_q[WIDTH-1:1]};
        res_d = {sum, res_q[WIDTH-1:1]};
        cy_d  = cout;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          // carry into the MSB cell is cy_q; out of it is cout
          s_d     = {sum, res_q[WIDTH-1:1]};
          c_d     = cout;
          v_d     = cout ^ cy_q;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      s_q     <= s_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign C    = c_q;
  assign V    = v_q;

endmodule
